reg_mux_n: RTL and testbench
============================

// Module: reg_mux_n
// PURPOSE
//   Registered N-way, W-bit selector with valid/ready flow control and select hold.
//   Generalises the 2:1 3-bit combinational datapath selector. Sits between multi-cycle
//   CPU stages (register-address select, ALU operand select). Lets a stage stall without
//   losing a selected value, and lets the control FSM freeze the select across cycles.
// PARAMETERS
//   WIDTH   3   data width of each input channel and of out_data
//   NUM_IN  2   number of input channels, >= 2
//   SEL_W   1   select width; must equal $clog2(NUM_IN), checked at elaboration
// PORTS
//   clk       in   1             rising-edge clock
//   reset     in   1             asynchronous, active-high reset
//   in_data   in   NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   sel       in   SEL_W         channel select for this transfer
//   sel_hold  in   1             1: use held select, ignore sel
//   in_valid  in   1             upstream offers a transfer
//   in_ready  out  1             block can accept a transfer
//   out_data  out  WIDTH         selected, registered data
//   out_valid out  1             out_data is valid
//   out_ready in   1             downstream accepts out_data
//   sel_err   out  1             1-cycle pulse: accepted transfer had sel >= NUM_IN
// BEHAVIOUR
//   - Reset (async, any time, mid-transfer included):
//       out_valid=0, out_data=0, sel_err=0, held select=0, skid buffer empty.
//       in_ready=1 from the first clk edge after reset deasserts.
//   - Effective select: eff_sel = sel_hold ? held_sel : sel.
//       held_sel <= sel on every accepted transfer with sel_hold=0.
//   - Selected value: in_data[eff_sel] if eff_sel < NUM_IN, else all-zero.
//   - Accept when in_valid & in_ready. Latency is 1 cycle: out_valid rises on the edge
//     after acceptance.
//   - Storage: output register plus a 1-entry skid register.
//       in_ready = ~skid_valid (registered, no combinational path from out_ready).
//   - Per-edge rules, with acc = accepted and pop = out_valid & out_ready:
//       out empty or pop, skid empty:  acc loads the output register.
//       out empty or pop, skid full:   skid moves to output; acc, if any, loads skid.
//       out full, no pop, acc:         acc loads skid; in_ready drops next cycle.
//       Simultaneous acc and pop with skid empty: output reloads, out_valid stays 1.
//   - Full: both registers valid; in_ready=0 until a pop.
//     Empty: out_valid=0; out_data holds its last value (don't-care).
//   - Hold semantics:
//       out_data and out_valid stay stable while out_valid & ~out_ready.
//       Data is never dropped or duplicated; order is preserved.
//   - sel_err pulses 1 cycle on the edge after acceptance of an out-of-range eff_sel.
//     It is not sticky, and the zero data is still delivered.
//   - NUM_IN a power of two: sel_err can never assert.
// STRUCTURE
//   - Package cpu_mux_pkg holds:
//       the function clog2_f;
//       the default widths REG_ADDR_W=3 and DATA_W=16 used when instantiating.
//   - One sub-module, mux_n_comb: pure combinational WIDTH x NUM_IN selector with an
//     out-of-range flag, reused by the output-register and skid paths.
//   - The top holds the skid/valid control and held_sel; no explicit FSM beyond the
//     two valid bits.
// TESTING
//   1. Basic path, WIDTH=3, NUM_IN=2:
//        in_data={3'd5,3'd2}, sel=1, out_ready=1, one in_valid pulse
//        -> next cycle out_data=5, out_valid=1 for exactly 1 cycle.
//   2. Stall:
//        out_ready=0, send 2 transfers (sel=0 -> 2, sel=1 -> 5)
//        -> in_ready=0 after the 2nd transfer, out_data=2 stable;
//        raise out_ready -> 2 then 5 emitted in order, in_ready=1 again.
//   3. Hold, NUM_IN=4, WIDTH=8, in_data={8'h44,8'h33,8'h22,8'h11}:
//        send with sel=2, sel_hold=0, then sel=0, sel_hold=1
//        -> outputs 8'h33, 8'h33.
//   4. Out of range, NUM_IN=3, sel=3
//        -> out_data=0, sel_err=1 for one cycle, out_valid=1.
//   5. Reset with both registers full:
//        -> out_valid=0, out_data=0, sel_err=0 immediately, without a clk edge;
//        after release, held_sel=0 (sel_hold=1 picks channel 0).
//   6. Throughput:
//        in_valid=1, out_ready=1 for 8 cycles with sel cycling 0,1
//        -> 8 outputs on consecutive cycles, in_ready never 0.

Source files
------------

// File: rtl/cpu_mux_pkg.sv
// Purpose : shared widths and elaboration helpers for the CPU operand/address selectors.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   REG_ADDR_W - register-address select width, default WIDTH for reg_mux_n
//   DATA_W     - ALU operand width, used when instantiating operand selectors
//   clog2_f    - ceil(log2(value)), usable in parameter expressions
package cpu_mux_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 16;

  // Number of bits needed to encode 'value' distinct indices (value >= 1).
  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purpose : combinational NUM_IN-way, WIDTH-bit selector with an out-of-range flag.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; no flow control in this block.
//
// Ports:
//   in_data      in  NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   sel          in  SEL_W         channel index
//   out_data     out WIDTH         selected channel, all-zero when sel is out of range
//   out_of_range out 1             sel does not name an existing channel
module mux_n_comb #(
  parameter int WIDTH  = 3,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_of_range
);

  // Decoding by equality against every legal index means an unmatched
  // select naturally falls through to zero data with the flag set, and for
  // a power-of-two NUM_IN every code matches so the flag can never rise.
  always_comb begin
    out_data     = '0;
    out_of_range = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data     = in_data[k*WIDTH +: WIDTH];
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_mux_n.sv
// Purpose : registered N-way selector with select hold, output register plus 1-entry skid.
// Latency : 1 cycle from acceptance to out_valid.
// Backpressure: in_ready is registered (~skid full); out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk       in   1             rising-edge clock
//   reset     in   1             asynchronous, active-high reset
//   in_data   in   NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
//   sel       in   SEL_W         channel select for this transfer
//   sel_hold  in   1             1: use the held select, ignore sel
//   in_valid  in   1             upstream offers a transfer
//   in_ready  out  1             block can accept a transfer
//   out_data  out  WIDTH         selected, registered data
//   out_valid out  1             out_data is valid
//   out_ready in   1             downstream accepts out_data
//   sel_err   out  1             1-cycle pulse: accepted transfer had an out-of-range select
module reg_mux_n
  import cpu_mux_pkg::*;
#(
  parameter int WIDTH  = REG_ADDR_W,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_hold,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  // Parameter sanity: a mismatched select width would silently alias or
  // hide channels, so refuse to elaborate instead.
  if (NUM_IN < 2) begin : g_bad_num_in
    $error("reg_mux_n: NUM_IN must be >= 2");
  end
  if (SEL_W != clog2_f(NUM_IN)) begin : g_bad_sel_w
    $error("reg_mux_n: SEL_W must equal clog2(NUM_IN)");
  end

  // State
  logic             out_vld_q,  out_vld_d;
  logic [WIDTH-1:0] out_dat_q,  out_dat_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             sel_err_q,  sel_err_d;
  logic [SEL_W-1:0] held_sel_q, held_sel_d;
  logic             in_rdy_q,   in_rdy_d;

  // Datapath
  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] sel_dat;
  logic             sel_oor;
  logic             acc;
  logic             pop;

  assign eff_sel = sel_hold ? held_sel_q : sel;

  // One selector serves both destinations: an accepted beat goes either to
  // the output register or to the skid register, never to both.
  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_data      (in_data),
    .sel          (eff_sel),
    .out_data     (sel_dat),
    .out_of_range (sel_oor)
  );

  assign acc = in_valid & in_rdy_q;
  assign pop = out_vld_q & out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    held_sel_d = held_sel_q;

    if (!out_vld_q || pop) begin
      // Output slot is free this edge.
      if (skid_vld_q) begin
        // Oldest beat lives in skid: it goes first to keep order, and a new
        // beat, if any, takes its place in skid.
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = acc;
        if (acc) begin
          skid_dat_d = sel_dat;
        end
      end else begin
        out_vld_d = acc;
        if (acc) begin
          out_dat_d = sel_dat;
        end
      end
    end else if (acc) begin
      // Output stalled: park the new beat. acc implies skid was empty.
      skid_vld_d = 1'b1;
      skid_dat_d = sel_dat;
    end

    if (acc && !sel_hold) begin
      held_sel_d = sel;
    end

    sel_err_d = acc & sel_oor;
    // Registered ready tracks the next skid state, so it comes up one edge
    // after reset releases and drops the cycle after skid fills.
    in_rdy_d  = ~skid_vld_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      sel_err_q  <= 1'b0;
      held_sel_q <= '0;
      in_rdy_q   <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      sel_err_q  <= sel_err_d;
      held_sel_q <= held_sel_d;
      in_rdy_q   <= in_rdy_d;
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_data  = out_dat_q;
  assign out_valid = out_vld_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_reg_mux_n.sv
// Purpose : self-checking bench for reg_mux_n in 2-, 3- and 4-channel configurations.
// Latency : n/a (testbench).
// Backpressure: n/a (testbench).
module tb_reg_mux_n;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- instance A: WIDTH=3, NUM_IN=2
  logic [5:0]  in_data2 = '0;
  logic [0:0]  sel2 = '0;
  logic        hold2 = 1'b0, iv2 = 1'b0, or2 = 1'b0;
  logic        ir2, ov2, err2;
  logic [2:0]  od2;
  reg_mux_n #(.WIDTH(3), .NUM_IN(2), .SEL_W(1)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data2), .sel(sel2), .sel_hold(hold2),
    .in_valid(iv2), .in_ready(ir2), .out_data(od2), .out_valid(ov2),
    .out_ready(or2), .sel_err(err2));

  // ---- instance B: WIDTH=8, NUM_IN=4
  logic [31:0] in_data4 = '0;
  logic [1:0]  sel4 = '0;
  logic        hold4 = 1'b0, iv4 = 1'b0, or4 = 1'b0;
  logic        ir4, ov4, err4;
  logic [7:0]  od4;
  reg_mux_n #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) u4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .sel(sel4), .sel_hold(hold4),
    .in_valid(iv4), .in_ready(ir4), .out_data(od4), .out_valid(ov4),
    .out_ready(or4), .sel_err(err4));

  // ---- instance C: WIDTH=8, NUM_IN=3 (has unreachable select codes)
  logic [23:0] in_data3 = '0;
  logic [1:0]  sel3 = '0;
  logic        hold3 = 1'b0, iv3 = 1'b0, or3 = 1'b0;
  logic        ir3, ov3, err3;
  logic [7:0]  od3;
  reg_mux_n #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .sel(sel3), .sel_hold(hold3),
    .in_valid(iv3), .in_ready(ir3), .out_data(od3), .out_valid(ov3),
    .out_ready(or3), .sel_err(err3));

  // Reference model state for the randomized run on instance C.
  logic [7:0]  exp_q[$];
  int          held;
  logic        err_pend;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  v;
    logic [23:0] shifted;
    logic [2:0]  prev2;
    int          eff;
    bit          acc, pop;

    // ---------------- reset state
    #3;
    chk("rst_ov", 32'(ov3), 32'd0);
    chk("rst_od", 32'(od3), 32'd0);
    chk("rst_err", 32'(err3), 32'd0);
    #19 reset = 1'b0;                  // t=22, away from an edge
    @(posedge clk); #1;
    chk("rst_ir_up", 32'(ir2), 32'd1);
    chk("rst_ov_idle", 32'(ov2), 32'd0);

    // ---------------- 1. basic path
    in_data2 = {3'd5, 3'd2}; sel2 = 1'b1; or2 = 1'b1; iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    chk("basic_ov", 32'(ov2), 32'd1);
    chk("basic_od", 32'(od2), 32'd5);
    chk("basic_err", 32'(err2), 32'd0);
    @(posedge clk); #1;
    chk("basic_ov_1cyc", 32'(ov2), 32'd0);

    // ---------------- 2. stall
    or2 = 1'b0; iv2 = 1'b1; sel2 = 1'b0;
    @(posedge clk); #1;
    sel2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    chk("stall_ir", 32'(ir2), 32'd0);
    chk("stall_od", 32'(od2), 32'd2);
    chk("stall_ov", 32'(ov2), 32'd1);
    @(posedge clk); #1;
    chk("stall_od_hold", 32'(od2), 32'd2);
    or2 = 1'b1;
    @(posedge clk); #1;
    chk("stall_od2", 32'(od2), 32'd5);
    chk("stall_ov2", 32'(ov2), 32'd1);
    chk("stall_ir_back", 32'(ir2), 32'd1);
    @(posedge clk); #1;
    chk("stall_drained", 32'(ov2), 32'd0);

    // ---------------- 3. hold
    in_data4 = {8'h44, 8'h33, 8'h22, 8'h11}; or4 = 1'b1; iv4 = 1'b1;
    sel4 = 2'd2; hold4 = 1'b0;
    @(posedge clk); #1;
    sel4 = 2'd0; hold4 = 1'b1;
    chk("hold_od1", 32'(od4), 32'h33);
    @(posedge clk); #1;
    iv4 = 1'b0;
    chk("hold_od2", 32'(od4), 32'h33);
    chk("hold_ov2", 32'(ov4), 32'd1);
    chk("hold_err_pow2", 32'(err4), 32'd0);

    // ---------------- 4. out of range
    in_data3 = {8'h77, 8'h66, 8'h55}; sel3 = 2'd3; hold3 = 1'b0; or3 = 1'b1; iv3 = 1'b1;
    @(posedge clk); #1;
    iv3 = 1'b0;
    chk("oor_od", 32'(od3), 32'd0);
    chk("oor_err", 32'(err3), 32'd1);
    chk("oor_ov", 32'(ov3), 32'd1);
    @(posedge clk); #1;
    chk("oor_err_pulse", 32'(err3), 32'd0);

    // ---------------- 5. reset with both registers full
    or3 = 1'b0; iv3 = 1'b1; sel3 = 2'd1; hold3 = 1'b0;
    @(posedge clk); #1;
    sel3 = 2'd2;
    @(posedge clk); #1;
    iv3 = 1'b0;
    chk("full_ir", 32'(ir3), 32'd0);
    chk("full_od", 32'(od3), 32'h66);
    #2 reset = 1'b1;
    #1;
    chk("arst_ov", 32'(ov3), 32'd0);
    chk("arst_od", 32'(od3), 32'd0);
    chk("arst_err", 32'(err3), 32'd0);
    #2 reset = 1'b0;
    in_data3 = {8'hC3, 8'hB2, 8'hA1}; hold3 = 1'b1; sel3 = 2'd2; or3 = 1'b1; iv3 = 1'b1;
    @(posedge clk); #1;
    chk("arst_ir_up", 32'(ir3), 32'd1);
    chk("arst_ov_idle", 32'(ov3), 32'd0);
    @(posedge clk); #1;
    iv3 = 1'b0;
    chk("arst_held0", 32'(od3), 32'hA1);
    chk("arst_held0_ov", 32'(ov3), 32'd1);
    @(posedge clk); #1;

    // ---------------- randomized run on instance C vs queue model
    held = 0; err_pend = 1'b0; exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      iv3      = 1'($urandom_range(0, 1));
      or3      = ($urandom_range(0, 3) != 0);
      sel3     = 2'($urandom_range(0, 3));
      hold3    = ($urandom_range(0, 3) == 0);
      in_data3 = 24'($urandom);
      @(negedge clk);
      chk("rnd_ov", 32'(ov3), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("rnd_od", 32'(od3), 32'(exp_q[0]));
      chk("rnd_ir", 32'(ir3), 32'(exp_q.size() < 2));
      chk("rnd_err", 32'(err3), 32'(err_pend));
      acc = iv3 && (exp_q.size() < 2);
      pop = or3 && (exp_q.size() > 0);
      eff = hold3 ? held : int'(sel3);
      shifted = in_data3 >> (8 * eff);
      v = (eff < 3) ? shifted[7:0] : 8'h00;
      @(posedge clk);
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(v);
        if (!hold3) held = int'(sel3);
      end
      err_pend = acc && (eff >= 3);
      #1;
    end
    iv3 = 1'b0;

    // ---------------- 6. throughput
    or2 = 1'b1; hold2 = 1'b0; prev2 = '0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("tput_ov", 32'(ov2), 32'd1);
        chk("tput_od", 32'(od2), 32'(prev2));
        chk("tput_ir", 32'(ir2), 32'd1);
      end
      if (i < 8) begin
        iv2      = 1'b1;
        sel2     = 1'(i % 2);
        in_data2 = 6'($urandom);
        prev2    = (i % 2 == 1) ? in_data2[5:3] : in_data2[2:0];
      end else begin
        iv2 = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("tput_drained", 32'(ov2), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
